// File: rtl/alu_issue_ctrl.sv
// Issue/sequence controller for the 16-bit ALU: handshake accept, operand fetch from an 8x16 RF, fixed-latency wait, writeback.
// Optional macro ALU_ISSUE_R0_ZERO_EN hardwires r0 to zero.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_sub,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    input  logic        alu_no,
    input  logic        alu_zo,
    output logic        done,
    output logic        dz,
    output logic [3:0]  flags,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
`ifdef ALU_ISSUE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     instr_q;
    logic            divz_q;
    logic [15:0]     rf_q [NREGS];
    logic [15:0]     alu_a_q, alu_b_q;
    logic [2:0]      alu_op_q;
    logic            alu_sub_q;
    logic            dz_q;
    logic [3:0]      flags_q;

    logic            accept;
    logic [2:0]      op_in;
    logic [15:0]     opnd_a, opnd_b;
    logic            is_alu_in, divz_in;
    logic            wb_we, flags_we, dz_set;
    logic [15:0]     wb_data;
    logic [3:0]      flags_new;
    logic [NREGS-1:0] rf_we;

    assign op_in     = in_instr[15:13];
    assign opnd_a    = rf_q[in_instr[9:7]];
    assign opnd_b    = rf_q[in_instr[6:4]];
    assign is_alu_in = (op_in <= 3'd5);
    assign divz_in   = (op_in == 3'd5) && (opnd_b == 16'h0000);
    assign accept    = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; EXEC spans exactly ALU_LAT cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_alu_in && !divz_in) begin
                        state_d = S_EXEC;
                        cnt_d   = CW'(ALU_LAT - 1);
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are masked during reset so an aborted instruction never signals
    always_comb begin
        in_ready = (state_q == S_IDLE) && !rst;
        done     = (state_q == S_WB) && !rst;
    end

    always_comb begin
        wb_we     = 1'b0;
        flags_we  = 1'b0;
        dz_set    = 1'b0;
        wb_data   = alu_result;
        flags_new = flags_q;
        if (state_q == S_WB) begin
            case (instr_q[15:13])
                3'd0, 3'd1: begin
                    wb_we     = 1'b1;
                    flags_we  = 1'b1;
                    flags_new = {alu_cout, alu_overflow, alu_no, alu_zo};
                end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    wb_we    = 1'b1;
                    flags_we = 1'b1;
                    if (instr_q[15:13] == 3'd5 && divz_q) begin
                        wb_data   = 16'hFFFF;
                        flags_new = 4'b0010;
                        dz_set    = 1'b1;
                    end else begin
                        flags_new = {2'b00, alu_result[15], alu_result == 16'h0000};
                    end
                end
                3'd6: begin
                    wb_we     = 1'b1;
                    flags_we  = 1'b1;
                    wb_data   = {6'b0, instr_q[9:0]};
                    flags_new = {3'b000, instr_q[9:0] == 10'd0};
                end
                default: ;
            endcase
        end
    end

    // r0 never takes a write when hardwired, so it reads back as its reset value
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
            assign rf_we[gi] = wb_we && (instr_q[12:10] == 3'(gi)) && !(R0_ZERO && gi == 0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            divz_q    <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_sub_q <= 1'b0;
            dz_q      <= 1'b0;
            flags_q   <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            if (accept) begin
                instr_q <= in_instr;
                divz_q  <= divz_in;
                if (is_alu_in) begin
                    alu_a_q   <= opnd_a;
                    alu_b_q   <= opnd_b;
                    alu_op_q  <= op_in;
                    alu_sub_q <= (op_in == 3'd1);
                end
            end
            if (flags_we) flags_q <= flags_new;
            if (dz_set)   dz_q    <= 1'b1;
            for (int i = 0; i < NREGS; i++) begin
                if (rf_we[i]) rf_q[i] <= wb_data;
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign alu_sub  = alu_sub_q;
    assign dz       = dz_q;
    assign flags    = flags_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule
